cnn_concat_channel: RTL and testbench
=====================================

// Module: cnn_concat_channel
// PURPOSE
//  Decoder-side channel concatenation, directly downstream of the x4 nearest-neighbour upsampler.
//  Merges the upsampled ASPP stream (A) with the low-level 1x1-conv stream (B) into one
//  channel-major stream: all CH_A channels of A, then all CH_B channels of B.
//  A is passed through; B is buffered in local RAM and drained once A is complete.
//  No backpressure: valid-only streaming on every port.
// PARAMETERS
//  DATA_WIDTH    16  pixel width (bits)
//  IMAGE_WIDTH   32  feature-map width after upsampling
//  IMAGE_HEIGHT  32  feature-map height after upsampling
//  CH_A           4  channels in stream A (upsampled)
//  CH_B           2  channels in stream B (low-level, buffered)
//  localparams: IMAGE_SIZE=W*H; A_TOTAL=CH_A*IMAGE_SIZE; B_TOTAL=CH_B*IMAGE_SIZE;
//               ADDR_WIDTH=clog2(B_TOTAL); CNT_WIDTH=clog2(max(A_TOTAL,B_TOTAL)+1)
// PORTS
//  clk         in   1           clock, rising edge
//  reset       in   1           asynchronous, active-low reset
//  valid_a     in   1           pxl_a valid (upsampler valid_out)
//  pxl_a       in   DATA_WIDTH  stream A pixel, channel-major raster
//  valid_b     in   1           pxl_b valid
//  pxl_b       in   DATA_WIDTH  stream B pixel, channel-major raster
//  valid_out   out  1           pxl_out valid
//  pxl_out     out  DATA_WIDTH  concatenated pixel
//  frame_done  out  1           1-cycle pulse with the last output pixel of a frame
//  err_ovf     out  1           sticky: input pixel arrived while its counter was full
// BEHAVIOUR
//  Reset (reset==0, async): valid_out=0, pxl_out=0, frame_done=0, err_ovf=0, state=S_PASS_A,
//   cnt_a=0, waddr=0, raddr=0. RAM contents are not cleared. Mid-frame reset discards the frame.
//  FSM: S_PASS_A -> S_DRAIN_B -> S_PASS_A (state encoding is implementation choice).
//  B write (any state): valid_b && waddr<B_TOTAL -> mem[waddr]<=pxl_b, waddr++.
//   valid_b && waddr==B_TOTAL -> pixel dropped, err_ovf<=1.
//  S_PASS_A: valid_a && cnt_a<A_TOTAL -> next cycle pxl_out=pxl_a, valid_out=1 (latency 1); cnt_a++.
//   When cnt_a reaches A_TOTAL (last A accepted) -> S_DRAIN_B. No valid_a -> valid_out=0.
//  S_DRAIN_B: valid_a -> dropped, err_ovf<=1 (A already complete).
//   Read issued when raddr<waddr (only already-written data); synchronous RAM read,
//   valid_out=1 with mem[raddr] one cycle after issue; raddr++ per issue. Otherwise valid_out=0.
//   B may arrive before, during or after A; drain stalls (valid_out=0) while raddr==waddr.
//   Same-cycle write to waddr and read of raddr<waddr is legal (different addresses).
//  Frame end: the cycle the read of address B_TOTAL-1 is presented, frame_done=1; the same edge
//   clears cnt_a, waddr, raddr and returns to S_PASS_A. valid_b in that cycle sees waddr==B_TOTAL:
//   overflow. valid_a in that cycle: overflow (still S_DRAIN_B).
//  Output ordering: A pixels never interleave with B pixels; at most one output per cycle.
//  Counters: unsigned, CNT_WIDTH/ADDR_WIDTH bits; compares against A_TOTAL/B_TOTAL, never wrap.
//  err_ovf cleared only by reset.
// STRUCTURE
//  Shared include param_def_concat_channel.v: DATA_WIDTH, IMAGE_WIDTH/HEIGHT, CH_A, CH_B and
//   derived IMAGE_SIZE, A_TOTAL, B_TOTAL, ADDR_WIDTH, CNT_WIDTH; state encodings as localparams.
//  One sub-module: cnn_concat_ram -- simple dual-port RAM (1W/1R, sync read, no reset),
//   depth B_TOTAL, width DATA_WIDTH, inferable as BRAM.
//  Top holds FSM, counters, output register, error flag.
// TESTING (bench uses W=H=4, CH_A=2, CH_B=1: A_TOTAL=32, B_TOTAL=16)
//  1 A then B: 32 valid_a (values 0..31), then 16 valid_b (100..115) -> out 0..31 then 100..115,
//    frame_done on pixel 115 only, err_ovf=0.
//  2 B first: 16 valid_b (100..115), then 32 valid_a -> out 0..31 each 1 cycle after input,
//    then 100..115 back-to-back, 48 outputs total.
//  3 Interleaved/gapped: random valid gaps on both inputs -> same order as 1, no lost or
//    duplicated pixel, valid_out never high while drain raddr==waddr.
//  4 Overflow: 33rd valid_a (value 99) before frame end -> 99 never appears, err_ovf=1 next
//    cycle and stays 1; 17th valid_b likewise.
//  5 Reset mid-frame: reset low after 10 A pixels -> valid_out=0, err_ovf=0 asynchronously;
//    fresh full frame afterwards matches scenario 1.
//  6 Two consecutive frames: second frame's data follows frame_done -> both frames correct,
//    frame_done pulses exactly twice.

Source files
------------

// File: rtl/cnn_concat_channel_pkg.sv
// Shared parameters, FSM state type and width helpers for the channel-concatenation block.
package cnn_concat_channel_pkg;

    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_IMAGE_WIDTH  = 32;
    localparam int DEF_IMAGE_HEIGHT = 32;
    localparam int DEF_CH_A         = 4;
    localparam int DEF_CH_B         = 2;

    typedef enum logic {
        S_PASS_A  = 1'b0,
        S_DRAIN_B = 1'b1
    } state_e;

    // Address width of a memory with n entries, never below one bit.
    function automatic int addr_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cnn_concat_channel_if.sv
// Valid-only stream bundle: two input streams, the concatenated output and status flags.
interface cnn_concat_channel_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  valid_a;
    logic [DATA_WIDTH-1:0] pxl_a;
    logic                  valid_b;
    logic [DATA_WIDTH-1:0] pxl_b;
    logic                  valid_out;
    logic [DATA_WIDTH-1:0] pxl_out;
    logic                  frame_done;
    logic                  err_ovf;

    modport master (
        output valid_a, pxl_a, valid_b, pxl_b,
        input  valid_out, pxl_out, frame_done, err_ovf
    );

    modport slave (
        input  valid_a, pxl_a, valid_b, pxl_b,
        output valid_out, pxl_out, frame_done, err_ovf
    );
endinterface

// File: rtl/cnn_concat_ram.sv
// Simple dual-port RAM: one write port, one registered read port, contents never reset.
module cnn_concat_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem[raddr_i];
        end
    end
endmodule

// File: rtl/cnn_concat_channel.sv
// Concatenates stream A (passed through) and stream B (buffered, drained after A) channel-major.
module cnn_concat_channel
    import cnn_concat_channel_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int CH_A         = DEF_CH_A,
    parameter int CH_B         = DEF_CH_B
) (
    input  logic                 clk,
    input  logic                 reset,
    cnn_concat_channel_if.slave  bus
);
    localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int A_TOTAL    = CH_A * IMAGE_SIZE;
    localparam int B_TOTAL    = CH_B * IMAGE_SIZE;
    localparam int ADDR_WIDTH = addr_bits(B_TOTAL);
    localparam int CNT_WIDTH  = $clog2(max2(A_TOTAL, B_TOTAL) + 1);

    localparam logic [CNT_WIDTH-1:0] A_TOTAL_C = CNT_WIDTH'(A_TOTAL);
    localparam logic [CNT_WIDTH-1:0] A_LAST_C  = CNT_WIDTH'(A_TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] B_TOTAL_C = CNT_WIDTH'(B_TOTAL);
    localparam logic [CNT_WIDTH-1:0] B_LAST_C  = CNT_WIDTH'(B_TOTAL - 1);

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_a_q, cnt_a_d;
    logic [CNT_WIDTH-1:0]  waddr_q, waddr_d;
    logic [CNT_WIDTH-1:0]  raddr_q, raddr_d;
    logic                  err_ovf_q, err_ovf_d;
    logic                  frame_done_q, frame_done_d;
    logic                  valid_out_q;
    logic                  sel_b_q;
    logic [DATA_WIDTH-1:0] pxl_a_q;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  a_fire, rd_fire, wr_fire;

    always_comb begin
        state_d      = state_q;
        cnt_a_d      = cnt_a_q;
        waddr_d      = waddr_q;
        raddr_d      = raddr_q;
        err_ovf_d    = err_ovf_q;
        a_fire       = 1'b0;
        rd_fire      = 1'b0;
        wr_fire      = bus.valid_b && (waddr_q < B_TOTAL_C);

        if (wr_fire) begin
            waddr_d = waddr_q + 1'b1;
        end else if (bus.valid_b) begin
            err_ovf_d = 1'b1;
        end

        case (state_q)
            S_PASS_A: begin
                if (bus.valid_a) begin
                    if (cnt_a_q < A_TOTAL_C) begin
                        a_fire  = 1'b1;
                        cnt_a_d = cnt_a_q + 1'b1;
                        if (cnt_a_q == A_LAST_C) begin
                            state_d = S_DRAIN_B;
                        end
                    end else begin
                        err_ovf_d = 1'b1;
                    end
                end
            end
            S_DRAIN_B: begin
                if (bus.valid_a) begin
                    err_ovf_d = 1'b1;
                end
                // Only already-written addresses are read; the drain stalls otherwise.
                if (raddr_q < waddr_q) begin
                    rd_fire = 1'b1;
                    raddr_d = raddr_q + 1'b1;
                end
            end
            default: state_d = S_PASS_A;
        endcase

        frame_done_d = rd_fire && (raddr_q == B_LAST_C);

        // Frame end: the edge after the last B pixel is presented starts a fresh frame.
        if (frame_done_q) begin
            state_d = S_PASS_A;
            cnt_a_d = '0;
            waddr_d = '0;
            raddr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_PASS_A;
            cnt_a_q      <= '0;
            waddr_q      <= '0;
            raddr_q      <= '0;
            err_ovf_q    <= 1'b0;
            frame_done_q <= 1'b0;
            valid_out_q  <= 1'b0;
            sel_b_q      <= 1'b0;
            pxl_a_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_a_q      <= cnt_a_d;
            waddr_q      <= waddr_d;
            raddr_q      <= raddr_d;
            err_ovf_q    <= err_ovf_d;
            frame_done_q <= frame_done_d;
            valid_out_q  <= a_fire || rd_fire;
            sel_b_q      <= rd_fire;
            if (a_fire) begin
                pxl_a_q <= bus.pxl_a;
            end
        end
    end

    cnn_concat_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (B_TOTAL),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_fire),
        .waddr_i (waddr_q[ADDR_WIDTH-1:0]),
        .wdata_i (bus.pxl_b),
        .re_i    (rd_fire),
        .raddr_i (raddr_q[ADDR_WIDTH-1:0]),
        .rdata_o (ram_rdata)
    );

    // The RAM output register doubles as the output register for B pixels.
    assign bus.valid_out  = valid_out_q;
    assign bus.pxl_out    = sel_b_q ? ram_rdata : pxl_a_q;
    assign bus.frame_done = frame_done_q;
    assign bus.err_ovf    = err_ovf_q;
endmodule

// File: tb/tb_cnn_concat_channel.sv
// Scoreboard bench for cnn_concat_channel on a 4x4 map, two A channels and one B channel.
module tb_cnn_concat_channel;
    localparam int DW      = 16;
    localparam int A_TOTAL = 32;
    localparam int B_TOTAL = 16;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          fd;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cnn_concat_channel_if #(.DATA_WIDTH(DW)) bus();

    cnn_concat_channel #(
        .DATA_WIDTH   (DW),
        .IMAGE_WIDTH  (4),
        .IMAGE_HEIGHT (4),
        .CH_A         (2),
        .CH_B         (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   fd_count = 0;
    int   frames   = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every presented output pops the oldest expected pixel.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (bus.frame_done === 1'b1) fd_count++;
            if (bus.valid_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got pixel %0d, expected no output", bus.pxl_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", int'(bus.pxl_out), int'(mon_e.d));
                    check("out_frame_done", int'(bus.frame_done), int'(mon_e.fd));
                    $display("out pixel=%0d frame_done=%0d (exp %0d/%0d)",
                             bus.pxl_out, bus.frame_done, mon_e.d, mon_e.fd);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        for (int i = 0; i < A_TOTAL; i++) exp_q.push_back('{d: DW'(i), fd: 1'b0});
        for (int j = 0; j < B_TOTAL; j++) exp_q.push_back('{d: DW'(100 + j), fd: (j == B_TOTAL - 1)});
        frames++;
    endtask

    task automatic drive_a(input int n, input int first, input int gap_max);
        for (int i = 0; i < n; i++) begin
            bus.valid_a = 1'b1;
            bus.pxl_a   = DW'(first + i);
            tick();
            bus.valid_a = 1'b0;
            if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) tick();
        end
    endtask

    task automatic drive_b(input int n, input int first, input int gap_max);
        for (int i = 0; i < n; i++) begin
            bus.valid_b = 1'b1;
            bus.pxl_b   = DW'(first + i);
            tick();
            bus.valid_b = 1'b0;
            if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) tick();
        end
    endtask

    // Bounded wait until every expected pixel has appeared, then step past the frame-end edge.
    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, exp_q.size(), 0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        bus.valid_a = 1'b0;
        bus.pxl_a   = '0;
        bus.valid_b = 1'b0;
        bus.pxl_b   = '0;
        #2 reset = 1'b0;
        #3;
        check("rst_valid_out", int'(bus.valid_out), 0);
        check("rst_pxl_out", int'(bus.pxl_out), 0);
        check("rst_frame_done", int'(bus.frame_done), 0);
        check("rst_err_ovf", int'(bus.err_ovf), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();

        // 1: all A, then all B
        push_frame();
        drive_a(A_TOTAL, 0, 0);
        drive_b(B_TOTAL, 100, 0);
        wait_drain("s1_drain");
        check("s1_err_ovf", int'(bus.err_ovf), 0);

        // 2: B first; A must pass with one-cycle latency
        push_frame();
        drive_b(B_TOTAL, 100, 0);
        for (int i = 0; i < A_TOTAL; i++) begin
            bus.valid_a = 1'b1;
            bus.pxl_a   = DW'(i);
            tick();
            check("s2_lat_valid", int'(bus.valid_out), 1);
            check("s2_lat_data", int'(bus.pxl_out), i);
        end
        bus.valid_a = 1'b0;
        wait_drain("s2_drain");

        // 3: both streams gapped and concurrent
        push_frame();
        fork
            drive_a(A_TOTAL, 0, 3);
            drive_b(B_TOTAL, 100, 4);
        join
        wait_drain("s3_drain");
        check("s3_err_ovf", int'(bus.err_ovf), 0);

        // 6: two frames back to back
        push_frame();
        drive_a(A_TOTAL, 0, 0);
        drive_b(B_TOTAL, 100, 0);
        wait_drain("s6_drain1");
        push_frame();
        fork
            drive_b(B_TOTAL, 100, 1);
            drive_a(A_TOTAL, 0, 0);
        join
        wait_drain("s6_drain2");
        check("s6_frame_done_count", fd_count, frames);
        check("s6_err_ovf", int'(bus.err_ovf), 0);

        // 4: overflow on both inputs
        push_frame();
        drive_a(A_TOTAL, 0, 0);
        check("s4_err_before", int'(bus.err_ovf), 0);
        bus.valid_a = 1'b1;
        bus.pxl_a   = DW'(99);
        tick();
        bus.valid_a = 1'b0;
        check("s4_err_a", int'(bus.err_ovf), 1);
        check("s4_drop_a_valid", int'(bus.valid_out), 0);
        drive_b(B_TOTAL, 100, 0);
        bus.valid_b = 1'b1;
        bus.pxl_b   = DW'(116);
        tick();
        bus.valid_b = 1'b0;
        check("s4_err_b", int'(bus.err_ovf), 1);
        wait_drain("s4_drain");
        check("s4_err_sticky", int'(bus.err_ovf), 1);

        // 5: reset after 10 A pixels, then a fresh frame
        for (int i = 0; i < 10; i++) exp_q.push_back('{d: DW'(i), fd: 1'b0});
        drive_a(10, 0, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("s5_rst_valid_out", int'(bus.valid_out), 0);
        check("s5_rst_err_ovf", int'(bus.err_ovf), 0);
        check("s5_rst_frame_done", int'(bus.frame_done), 0);
        check("s5_partial_seen", exp_q.size(), 0);
        tick();
        reset = 1'b1;
        tick();
        push_frame();
        drive_a(A_TOTAL, 0, 0);
        drive_b(B_TOTAL, 100, 0);
        wait_drain("s5_drain");
        check("s5_err_ovf", int'(bus.err_ovf), 0);

        repeat (3) tick();
        check("final_frame_done_count", fd_count, frames);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
